// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: word sizes, length width and
// the loader state encoding.
package program_loader_pkg;

  localparam int HALF_WORD        = 16;
  localparam int WORD             = 32;
  localparam int LOADER_LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed little-endian byte image over a
// valid/ready handshake, writes it halfword by halfword into CPU program
// memory and holds the CPU in reset until the image is fully written.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
//
// Handshake: a byte moves on a rising clk_i edge where byte_valid_i and
// byte_ready_o are both high. byte_ready_o depends only on the current state,
// so the upstream side may hold byte_valid_i for any number of cycles and
// lowering it simply stalls the loader with no side effects.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          MAX_HALFWORDS = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 cpu_reset_o,
  output logic                 load_done_o,
  output logic                 load_error_o
);

  localparam logic [LOADER_LEN_WIDTH-1:0] MAX_LEN = LOADER_LEN_WIDTH'(MAX_HALFWORDS);

  loader_state_t               state_q;
  logic [LOADER_LEN_WIDTH-1:0] len_q;
  logic [LOADER_LEN_WIDTH-1:0] idx_q;
  logic [7:0]                  lo_byte_q;
  logic [HALF_WORD-1:0]        instr_q;
  logic [WORD-1:0]             addr_q;
  logic                        we_q;
  logic                        cpu_reset_q;
  logic                        done_q;
  logic                        error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]                  chk_q;
`endif

  logic                        xfer;
  logic [LOADER_LEN_WIDTH-1:0] len_d;
  logic [LOADER_LEN_WIDTH-1:0] idx_d;

  // Ready decodes from state alone; next-length and next-index helpers.
  always_comb begin
    byte_ready_o = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                   (state_q == DATA_LO) || (state_q == DATA_HI)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                   || (state_q == CHK)
`endif
                   ;
    xfer  = byte_valid_i && byte_ready_o;
    len_d = {byte_i, len_q[7:0]};
    idx_d = idx_q + 1'b1;
  end

  // Loader FSM with all outputs registered; reset wins over a same-cycle byte.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= LEN_LO;
      len_q       <= '0;
      idx_q       <= '0;
      lo_byte_q   <= '0;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        LEN_LO: begin
          if (xfer) begin
            len_q   <= {8'h00, byte_i};
            state_q <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_q <= len_d;
            if (len_d == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_q <= CHK;
`else
              state_q     <= DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
`endif
            end else if (len_d > MAX_LEN) begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end else begin
              state_q <= DATA_LO;
            end
          end
        end
        DATA_LO: begin
          if (xfer) begin
            lo_byte_q <= byte_i;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q     <= chk_q ^ byte_i;
`endif
            state_q   <= DATA_HI;
          end
        end
        DATA_HI: begin
          // Strobe, data and address are registered here so they all appear
          // together during the single WRITE cycle.
          if (xfer) begin
            instr_q <= {byte_i, lo_byte_q};
            addr_q  <= BASE_ADDR + WORD'({idx_q, 1'b0});
            we_q    <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q   <= chk_q ^ byte_i;
`endif
            state_q <= WRITE;
          end
        end
        WRITE: begin
          idx_q <= idx_d;
          if (idx_d == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_q <= CHK;
`else
            state_q     <= DONE;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
`endif
          end else begin
            state_q <= DATA_LO;
          end
        end
        CHK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (xfer) begin
            if (byte_i == chk_q) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
`else
          state_q <= ERROR;
          error_q <= 1'b1;
`endif
        end
        DONE:    state_q <= DONE;
        ERROR:   state_q <= ERROR;
        default: state_q <= ERROR;
      endcase
    end
  end

  assign program_mem_write_en_o = we_q;
  assign instruction_o          = instr_q;
  assign instruction_addr_o     = addr_q;
  assign cpu_reset_o            = cpu_reset_q;
  assign load_done_o            = done_q;
  assign load_error_o           = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Writes are checked against an expected
// queue of {address, halfword}; status outputs are checked at fixed points.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFC0;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        program_mem_write_en_o;
  logic [15:0] instruction_o;
  logic [31:0] instruction_addr_o;
  logic        cpu_reset_o;
  logic        load_done_o;
  logic        load_error_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  int prev_pulse_cyc = 0;
  logic [47:0] exp_q[$];

  program_loader #(
    .BASE_ADDR(BASE),
    .MAX_HALFWORDS(1024)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .byte_valid_i(byte_valid_i),
    .byte_i(byte_i),
    .byte_ready_o(byte_ready_o),
    .program_mem_write_en_o(program_mem_write_en_o),
    .instruction_o(instruction_o),
    .instruction_addr_o(instruction_addr_o),
    .cpu_reset_o(cpu_reset_o),
    .load_done_o(load_done_o),
    .load_error_o(load_error_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (program_mem_write_en_o === 1'b1) begin
      pulses++;
      prev_pulse_cyc = last_pulse_cyc;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) check("wr_unexpected", 48'(exp_q.size()), 48'd1);
      else check("wr_addr_data", {instruction_addr_o, instruction_o}, exp_q.pop_front());
    end
  end

  // driver tasks (all start and end on a falling edge)
  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 48'(byte_ready_o), 48'd1);
    check({tag, "_we"}, 48'(program_mem_write_en_o), 48'd0);
    check({tag, "_instr"}, 48'(instruction_o), 48'd0);
    check({tag, "_addr"}, 48'(instruction_addr_o), 48'(BASE));
    check({tag, "_cpu_rst"}, 48'(cpu_reset_o), 48'd1);
    check({tag, "_done"}, 48'(load_done_o), 48'd0);
    check({tag, "_err"}, 48'(load_error_o), 48'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    byte_valid_i = 1'b1;
    byte_i = b;
    while (!byte_ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready_o) begin
      check("byte_ready_timeout", 48'(byte_ready_o), 48'd1);
      byte_valid_i = 1'b0;
    end else begin
      @(negedge clk);
      byte_valid_i = 1'b0;
    end
  endtask

  task automatic send_hw(input logic [15:0] d, input int gap);
    send_byte(d[7:0], gap);
    send_byte(d[15:8], gap);
  endtask

  task automatic push_hw(input int idx, input logic [15:0] d);
    logic [31:0] a;
    a = BASE + 32'(idx * 2);
    exp_q.push_back({a, d});
  endtask

  task automatic finish_image(input logic [7:0] chk);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(chk, 0);
`else
    if (chk !== 8'hxx) @(negedge clk);
`endif
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, 48'(load_done_o), 48'd1);
    check({tag, "_err"}, 48'(load_error_o), 48'd0);
    check({tag, "_cpu_rst"}, 48'(cpu_reset_o), 48'd0);
    check({tag, "_ready"}, 48'(byte_ready_o), 48'd0);
  endtask

  initial begin
    int base;
    logic [15:0] d;
    logic [7:0] x;
    reset_i = 1'b1;
    byte_valid_i = 1'b0;
    byte_i = 8'h00;
    @(negedge clk);
    do_reset();

    // two-halfword image, back to back
    base = pulses;
    push_hw(0, 16'h2001);
    push_hw(1, 16'h2102);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_hw(16'h2001, 0);
    send_hw(16'h2102, 0);
    check("t1_cpu_rst_in_write", 48'(cpu_reset_o), 48'd1);
    check("t1_done_in_write", 48'(load_done_o), 48'd0);
    finish_image(8'h02);
    check_done("t1");
    check("t1_pulses", 48'(pulses - base), 48'd2);
    check("t1_pulse_spacing", 48'(last_pulse_cyc - prev_pulse_cyc), 48'd3);

    // empty image
    do_reset();
    base = pulses;
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    check_done("t2");
    @(negedge clk);
    check("t2_pulses", 48'(pulses - base), 48'd0);

    // length 1025 exceeds the limit
    do_reset();
    base = pulses;
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    check("t3_err", 48'(load_error_o), 48'd1);
    check("t3_done", 48'(load_done_o), 48'd0);
    check("t3_cpu_rst", 48'(cpu_reset_o), 48'd1);
    check("t3_ready", 48'(byte_ready_o), 48'd0);
    repeat (3) @(negedge clk);
    check("t3_pulses", 48'(pulses - base), 48'd0);
    check("t3_err_held", 48'(load_error_o), 48'd1);

    // 64 halfwords with random stalls; address wraps past 2^32
    do_reset();
    base = pulses;
    x = 8'h00;
    send_byte(8'h40, $urandom_range(0, 5)); send_byte(8'h00, $urandom_range(0, 5));
    for (int i = 0; i < 64; i++) begin
      d = {8'(i + 8'h80), 8'(i * 3)};
      push_hw(i, d);
      x = x ^ d[7:0] ^ d[15:8];
      send_byte(d[7:0], $urandom_range(0, 5));
      send_byte(d[15:8], $urandom_range(0, 5));
    end
    finish_image(x);
    check_done("t4");
    check("t4_pulses", 48'(pulses - base), 48'd64);
    check("t4_queue_empty", 48'(exp_q.size()), 48'd0);

    // reset after 3 of 5 halfwords, byte offered during reset is dropped
    do_reset();
    base = pulses;
    send_byte(8'h05, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      push_hw(i, 16'h4000 + 16'(i));
      send_hw(16'h4000 + 16'(i), 0);
    end
    reset_i = 1'b1;
    byte_valid_i = 1'b1;
    byte_i = 8'h09;
    @(negedge clk);
    check_reset_vals("t5_rst_a");
    @(negedge clk);
    check_reset_vals("t5_rst_b");
    reset_i = 1'b0;
    byte_valid_i = 1'b0;
    push_hw(0, 16'hCDAB);
    push_hw(1, 16'h1234);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_hw(16'hCDAB, 0);
    send_hw(16'h1234, 1);
    finish_image(8'hAB ^ 8'hCD ^ 8'h34 ^ 8'h12);
    check_done("t5");
    check("t5_pulses", 48'(pulses - base), 48'd5);
    check("t5_queue_empty", 48'(exp_q.size()), 48'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // checksum good / bad
    do_reset();
    push_hw(0, 16'h1234);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_hw(16'h1234, 0);
    send_byte(8'h26, 0);
    check_done("t6_good");
    do_reset();
    push_hw(0, 16'h1234);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_hw(16'h1234, 0);
    send_byte(8'h27, 0);
    check("t6_bad_err", 48'(load_error_o), 48'd1);
    check("t6_bad_done", 48'(load_done_o), 48'd0);
    check("t6_bad_cpu_rst", 48'(cpu_reset_o), 48'd1);
    check("t6_queue_empty", 48'(exp_q.size()), 48'd0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
